// File: rtl/counter_updown_load.sv
// Parametrised up/down counter with load, programmable modulo limit, wrap or saturate
// behaviour, terminal-count pulse, sticky overflow/underflow flags and compare match.
module counter_updown_load #(
    parameter int unsigned      WIDTH    = 32,
    parameter bit               SATURATE = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cl,
    input  logic             w,
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             udf,
    output logic             match
);

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic count_up;
    logic count_down;
    logic up_bound;
    logic down_bound;

    // Both or neither direction enabled means hold.
    assign count_up   = up & ~down;
    assign count_down = down & ~up;

    // >= so a value loaded above the limit still takes the boundary on the next up edge.
    assign up_bound   = (q_q >= limit);
    assign down_bound = (q_q == '0);

    always_comb begin
        q_d   = q_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (cl) begin
            q_d   = '0;
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else if (w) begin
            q_d = d;
        end else if (count_up) begin
            if (up_bound) begin
                q_d   = SATURATE ? limit : '0;
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end else begin
                q_d = q_q + One;
            end
        end else if (count_down) begin
            if (down_bound) begin
                q_d   = SATURATE ? '0 : limit;
                tc_d  = 1'b1;
                udf_d = 1'b1;
            end else begin
                q_d = q_q - One;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= RST_VAL;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign q     = q_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;
    assign match = (q_q == cmp);

endmodule

// File: tb/tb_counter_updown_load.sv
// Bench for counter_updown_load: three instances (8-bit wrap, 8-bit saturate with non-zero
// reset value, 32-bit wrap) share stimulus; directed scenarios plus randomized model compare.
module tb_counter_updown_load;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cl, w, up, down;
    logic [31:0] d, limit, cmp;

    logic [7:0]  q_a, q_b;
    logic [31:0] q_c;
    logic        tc_a, tc_b, tc_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        udf_a, udf_b, udf_c;
    logic        match_a, match_b, match_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_updown_load #(.WIDTH(8), .SATURATE(1'b0), .RST_VAL(8'h00)) u_a (
        .clk(clk), .rst(rst), .cl(cl), .w(w), .d(d[7:0]), .up(up), .down(down),
        .limit(limit[7:0]), .cmp(cmp[7:0]), .q(q_a), .tc(tc_a), .ovf(ovf_a), .udf(udf_a),
        .match(match_a)
    );

    counter_updown_load #(.WIDTH(8), .SATURATE(1'b1), .RST_VAL(8'h10)) u_b (
        .clk(clk), .rst(rst), .cl(cl), .w(w), .d(d[7:0]), .up(up), .down(down),
        .limit(limit[7:0]), .cmp(cmp[7:0]), .q(q_b), .tc(tc_b), .ovf(ovf_b), .udf(udf_b),
        .match(match_b)
    );

    counter_updown_load #(.WIDTH(32), .SATURATE(1'b0), .RST_VAL(32'h0)) u_c (
        .clk(clk), .rst(rst), .cl(cl), .w(w), .d(d), .up(up), .down(down),
        .limit(limit), .cmp(cmp), .q(q_c), .tc(tc_c), .ovf(ovf_c), .udf(udf_c),
        .match(match_c)
    );

    logic [31:0] o_q[NI];
    logic        o_tc[NI], o_ovf[NI], o_udf[NI], o_match[NI];
    assign o_q[0] = {24'b0, q_a};
    assign o_q[1] = {24'b0, q_b};
    assign o_q[2] = q_c;
    assign o_tc[0] = tc_a;     assign o_tc[1] = tc_b;     assign o_tc[2] = tc_c;
    assign o_ovf[0] = ovf_a;   assign o_ovf[1] = ovf_b;   assign o_ovf[2] = ovf_c;
    assign o_udf[0] = udf_a;   assign o_udf[1] = udf_b;   assign o_udf[2] = udf_c;
    assign o_match[0] = match_a; assign o_match[1] = match_b; assign o_match[2] = match_c;

    // Reference model: counter value as a plain integer modulo 2^width.
    int unsigned     p_width[NI] = '{8, 8, 32};
    bit              p_sat[NI]   = '{1'b0, 1'b1, 1'b0};
    longint unsigned p_rst[NI]   = '{64'd0, 64'd16, 64'd0};
    longint unsigned m_q[NI];
    bit              m_tc[NI], m_ovf[NI], m_udf[NI];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_q[i]   = p_rst[i];
            m_tc[i]  = 1'b0;
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        longint unsigned modulus, lim, dv;
        for (int i = 0; i < NI; i++) begin
            modulus = 64'd1 << p_width[i];
            lim     = {32'b0, limit} % modulus;
            dv      = {32'b0, d} % modulus;
            m_tc[i] = 1'b0;
            if (cl) begin
                m_q[i]   = 0;
                m_ovf[i] = 1'b0;
                m_udf[i] = 1'b0;
            end else if (w) begin
                m_q[i] = dv;
            end else if (up && !down) begin
                if (m_q[i] >= lim) begin
                    m_q[i]   = p_sat[i] ? lim : 0;
                    m_tc[i]  = 1'b1;
                    m_ovf[i] = 1'b1;
                end else begin
                    m_q[i] = (m_q[i] + 1) % modulus;
                end
            end else if (down && !up) begin
                if (m_q[i] == 0) begin
                    m_q[i]   = p_sat[i] ? 0 : lim;
                    m_tc[i]  = 1'b1;
                    m_udf[i] = 1'b1;
                end else begin
                    m_q[i] = m_q[i] - 1;
                end
            end
        end
    endtask

    // Advance model and DUT by one edge; returns 1 time unit after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cl = 1'b0; w = 1'b0; up = 1'b0; down = 1'b0;
        d = '0; limit = '0; cmp = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (q_a !== 8'h00) begin errors++; $display("FAIL reset_q_a got %0h exp 0", q_a); end
        checks++;
        if (q_b !== 8'h10) begin errors++; $display("FAIL reset_q_b got %0h exp 10", q_b); end
        checks++;
        if (q_c !== 32'h0) begin errors++; $display("FAIL reset_q_c got %0h exp 0", q_c); end
        checks++;
        if ({tc_a, ovf_a, udf_a, tc_b, ovf_b, udf_b, tc_c, ovf_c, udf_c} !== 9'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0",
                     {tc_a, ovf_a, udf_a, tc_b, ovf_b, udf_b, tc_c, ovf_c, udf_c});
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp_q[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
        idle_inputs();
        pulse_reset();
        limit = 32'd5;
        up    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (q_a !== 8'(exp_q[k])) begin
                errors++; $display("FAIL wrap_q[%0d] got %0d exp %0d", k, q_a, exp_q[k]);
            end
            checks++;
            if (tc_a !== (k == 5)) begin
                errors++; $display("FAIL wrap_tc[%0d] got %b exp %b", k, tc_a, (k == 5));
            end
        end
        checks++;
        if (ovf_a !== 1'b1) begin errors++; $display("FAIL wrap_ovf got %b exp 1", ovf_a); end
        up = 1'b0;
    endtask

    task automatic test_saturate_down();
        int exp_q[5] = '{2, 1, 0, 0, 0};
        bit exp_tc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        idle_inputs();
        limit = 32'd5;
        w = 1'b1; d = 32'd3;
        cycle();
        w = 1'b0; down = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (q_b !== 8'(exp_q[k])) begin
                errors++; $display("FAIL sat_q[%0d] got %0d exp %0d", k, q_b, exp_q[k]);
            end
            checks++;
            if (tc_b !== exp_tc[k]) begin
                errors++; $display("FAIL sat_tc[%0d] got %b exp %b", k, tc_b, exp_tc[k]);
            end
        end
        checks++;
        if (udf_b !== 1'b1) begin errors++; $display("FAIL sat_udf got %b exp 1", udf_b); end
        down = 1'b0; cl = 1'b1;
        cycle();
        cl = 1'b0;
        checks++;
        if ({q_b, udf_b, ovf_b} !== 10'b0) begin
            errors++; $display("FAIL sat_clear got q=%0h udf=%b ovf=%b exp 0", q_b, udf_b, ovf_b);
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        limit = 32'hFF;
        cl = 1'b1; w = 1'b1; up = 1'b1; d = 32'h7;
        cycle();
        checks++;
        if (q_a !== 8'h0) begin errors++; $display("FAIL prio_cl got %0h exp 0", q_a); end
        cl = 1'b0;
        cycle();
        checks++;
        if (q_a !== 8'h7) begin errors++; $display("FAIL prio_w got %0h exp 7", q_a); end
        w = 1'b0; down = 1'b1;
        cycle();
        checks++;
        if (q_a !== 8'h7 || tc_a !== 1'b0) begin
            errors++; $display("FAIL prio_hold got q=%0h tc=%b exp q=7 tc=0", q_a, tc_a);
        end
        up = 1'b0; down = 1'b0;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        limit = 32'd3;
        cl = 1'b1;
        cycle();
        cl = 1'b0; up = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        checks++;
        if (q_b !== 8'd3 || ovf_b !== 1'b1 || tc_b !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got q=%0h ovf=%b tc=%b exp q=3 ovf=1 tc=1", q_b, ovf_b, tc_b);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (q_b !== 8'h10 || {tc_b, ovf_b, udf_b} !== 3'b0) begin
            errors++;
            $display("FAIL async_rst got q=%0h flags=%b exp q=10 flags=000", q_b,
                     {tc_b, ovf_b, udf_b});
        end
        rst = 1'b0;
        limit = 32'hFF;
        cycle();
        checks++;
        if (q_b !== 8'h11) begin errors++; $display("FAIL async_resume got %0h exp 11", q_b); end
        up = 1'b0;
    endtask

    task automatic test_load_above();
        idle_inputs();
        limit = 32'd4;
        w = 1'b1; d = 32'd9;
        cycle();
        w = 1'b0; up = 1'b1;
        cycle();
        checks++;
        if (q_a !== 8'd0 || tc_a !== 1'b1) begin
            errors++; $display("FAIL above_up got q=%0d tc=%b exp q=0 tc=1", q_a, tc_a);
        end
        up = 1'b0; w = 1'b1;
        cycle();
        w = 1'b0; down = 1'b1;
        cycle();
        checks++;
        if (q_a !== 8'd8 || tc_a !== 1'b0) begin
            errors++; $display("FAIL above_down got q=%0d tc=%b exp q=8 tc=0", q_a, tc_a);
        end
        down = 1'b0;
    endtask

    task automatic test_match();
        idle_inputs();
        limit = 32'hFF; cmp = 32'd3; cl = 1'b1;
        cycle();
        cl = 1'b0; up = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            checks++;
            if (match_a !== (k == 3)) begin
                errors++; $display("FAIL match[%0d] got %b exp %b", k, match_a, (k == 3));
            end
        end
        up = 1'b0;
        cmp = 32'd5;
        #1;
        checks++;
        if (match_a !== 1'b1) begin errors++; $display("FAIL match_comb got %b exp 1", match_a); end
    endtask

    task automatic test_wide();
        idle_inputs();
        limit = 32'hFFFF_FFFF;
        w = 1'b1; d = 32'hFFFF_FFFE; cl = 1'b0;
        cycle();
        w = 1'b0; up = 1'b1;
        cycle();
        checks++;
        if (q_c !== 32'hFFFF_FFFF || tc_c !== 1'b0) begin
            errors++; $display("FAIL wide_1 got q=%0h tc=%b exp q=ffffffff tc=0", q_c, tc_c);
        end
        cycle();
        checks++;
        if (q_c !== 32'h0 || tc_c !== 1'b1 || ovf_c !== 1'b1) begin
            errors++;
            $display("FAIL wide_2 got q=%0h tc=%b ovf=%b exp q=0 tc=1 ovf=1", q_c, tc_c, ovf_c);
        end
        up = 1'b0;
    endtask

    task automatic test_limit_zero();
        idle_inputs();
        cl = 1'b1;
        cycle();
        cl = 1'b0; up = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if (q_a !== 8'd0 || tc_a !== 1'b1) begin
                errors++; $display("FAIL lim0_up[%0d] got q=%0d tc=%b exp q=0 tc=1", k, q_a, tc_a);
            end
        end
        up = 1'b0; down = 1'b1;
        cycle();
        checks++;
        if (q_a !== 8'd0 || tc_a !== 1'b1 || udf_a !== 1'b1) begin
            errors++;
            $display("FAIL lim0_down got q=%0d tc=%b udf=%b exp 0 1 1", q_a, tc_a, udf_a);
        end
        down = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] cmp_m;
        idle_inputs();
        pulse_reset();
        for (int n = 0; n < 600; n++) begin
            cl   = ($urandom_range(0, 39) == 0);
            w    = ($urandom_range(0, 11) == 0);
            up   = $urandom_range(0, 1) == 1;
            down = $urandom_range(0, 2) == 0;
            d    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) : $urandom;
            cmp  = 32'($urandom_range(0, 12));
            case ($urandom_range(0, 7))
                0:       limit = '0;
                1:       limit = 32'hFFFF_FFFF;
                2:       limit = $urandom;
                default: limit = 32'($urandom_range(1, 12));
            endcase
            cycle();
            for (int i = 0; i < NI; i++) begin
                cmp_m = (p_width[i] == 32) ? cmp : (cmp & 32'hFF);
                checks++;
                if ({32'b0, o_q[i]} !== m_q[i]) begin
                    errors++; $display("FAIL rnd_q[%0d] i%0d got %0h exp %0h", n, i, o_q[i], m_q[i]);
                end
                checks++;
                if ({o_tc[i], o_ovf[i], o_udf[i]} !== {m_tc[i], m_ovf[i], m_udf[i]}) begin
                    errors++;
                    $display("FAIL rnd_flags[%0d] i%0d got %b exp %b", n, i,
                             {o_tc[i], o_ovf[i], o_udf[i]}, {m_tc[i], m_ovf[i], m_udf[i]});
                end
                checks++;
                if (o_match[i] !== ({32'b0, cmp_m} == m_q[i])) begin
                    errors++;
                    $display("FAIL rnd_match[%0d] i%0d got %b exp %b", n, i, o_match[i],
                             ({32'b0, cmp_m} == m_q[i]));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_priority();
        test_async_reset();
        test_load_above();
        test_match();
        test_wide();
        test_limit_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
